// File: rtl/imem_loader.sv
// Boot-time program loader: assembles a length-prefixed little-endian byte stream into
// 32-bit words, writes them to sequential imem addresses and verifies an XOR checksum.
module imem_loader #(
  parameter int DEPTH  = 256,
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              restart,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              cpu_rst,
  output logic              done,
  output logic              error
);

  typedef enum logic [2:0] {
    S_LEN0,
    S_LEN1,
    S_DATA,
    S_CSUM,
    S_DONE,
    S_ERR
  } state_t;

  state_t            state_reg, state_next;
  logic [15:0]       len_reg, len_next;
  logic [1:0]        byte_cnt_reg, byte_cnt_next;
  logic [ADDR_W-1:0] word_idx_reg, word_idx_next;
  logic [7:0]        csum_reg, csum_next;
  logic [23:0]       shift_reg, shift_next;

  logic              we_next;
  logic [ADDR_W-1:0] addr_next;
  logic [31:0]       wdata_next;
  logic              cpu_rst_next, done_next, error_next;

  logic              accept;
  logic [15:0]       len_field;
  logic              len_bad;
  logic              last_word;

  assign in_ready  = ((state_reg == S_LEN0) || (state_reg == S_LEN1) ||
                      (state_reg == S_DATA) || (state_reg == S_CSUM)) && !restart;
  assign accept    = in_valid && in_ready;
  assign len_field = {in_data, len_reg[7:0]};
  assign len_bad   = (len_field == 16'd0) || (32'(len_field) > 32'(DEPTH));
  assign last_word = (32'(word_idx_reg) == (32'(len_reg) - 32'd1));

  always_comb begin
    state_next    = state_reg;
    len_next      = len_reg;
    byte_cnt_next = byte_cnt_reg;
    word_idx_next = word_idx_reg;
    csum_next     = csum_reg;
    shift_next    = shift_reg;
    we_next       = 1'b0;
    addr_next     = imem_addr;
    wdata_next    = imem_wdata;

    if (restart) begin
      // Abandon everything, including any partially assembled word.
      state_next    = S_LEN0;
      len_next      = 16'd0;
      byte_cnt_next = 2'd0;
      word_idx_next = '0;
      csum_next     = 8'd0;
      shift_next    = 24'd0;
    end else if (accept) begin
      case (state_reg)
        S_LEN0: begin
          len_next   = {8'd0, in_data};
          state_next = S_LEN1;
        end
        S_LEN1: begin
          len_next   = len_field;
          state_next = len_bad ? S_ERR : S_DATA;
        end
        S_DATA: begin
          csum_next     = csum_reg ^ in_data;
          byte_cnt_next = byte_cnt_reg + 2'd1;
          if (byte_cnt_reg == 2'd3) begin
            we_next    = 1'b1;
            addr_next  = word_idx_reg;
            wdata_next = {in_data, shift_reg};
            if (last_word) begin
              state_next = S_CSUM;
            end else begin
              word_idx_next = word_idx_reg + 1'b1;
            end
          end else begin
            // Earlier bytes enter at the top and drift down to the low lanes.
            shift_next = {in_data, shift_reg[23:8]};
          end
        end
        S_CSUM: begin
          state_next = (in_data == csum_reg) ? S_DONE : S_ERR;
        end
        default: begin
          state_next = state_reg;
        end
      endcase
    end

    done_next    = (state_next == S_DONE);
    error_next   = (state_next == S_ERR);
    cpu_rst_next = (state_next != S_DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= S_LEN0;
      len_reg      <= 16'd0;
      byte_cnt_reg <= 2'd0;
      word_idx_reg <= '0;
      csum_reg     <= 8'd0;
      shift_reg    <= 24'd0;
      imem_we      <= 1'b0;
      imem_addr    <= '0;
      imem_wdata   <= 32'd0;
      cpu_rst      <= 1'b1;
      done         <= 1'b0;
      error        <= 1'b0;
    end else begin
      state_reg    <= state_next;
      len_reg      <= len_next;
      byte_cnt_reg <= byte_cnt_next;
      word_idx_reg <= word_idx_next;
      csum_reg     <= csum_next;
      shift_reg    <= shift_next;
      imem_we      <= we_next;
      imem_addr    <= addr_next;
      imem_wdata   <= wdata_next;
      cpu_rst      <= cpu_rst_next;
      done         <= done_next;
      error        <= error_next;
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Randomized bench for imem_loader: frames are built from random words, the expected
// write list and done/error outcome come from a frame-level model.
module tb_imem_loader;

  localparam int DEPTH  = 256;
  localparam int ADDR_W = 8;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              restart = 1'b0;
  logic              in_valid = 1'b0;
  logic [7:0]        in_data = 8'd0;
  logic              in_ready;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_wdata;
  logic              cpu_rst;
  logic              done;
  logic              error;

  int checks = 0;
  int errors = 0;

  logic [39:0] obs_q[$];
  logic [39:0] exp_q[$];
  logic [31:0] words[DEPTH+1];

  imem_loader #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst(rst), .restart(restart),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
    .cpu_rst(cpu_rst), .done(done), .error(error)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (imem_we) obs_q.push_back({imem_addr, imem_wdata});
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input int max_stall);
    bit sent = 0;
    in_valid = 1'b0;
    idle($urandom_range(0, max_stall));
    in_valid = 1'b1;
    in_data  = b;
    for (int i = 0; i < 100 && !sent; i++) begin
      @(negedge clk);
      if (in_ready) begin
        @(posedge clk);
        #1;
        sent = 1;
      end
    end
    in_valid = 1'b0;
    if (!sent) check("send_timeout", 0, 1);
  endtask

  task automatic pulse_restart();
    @(posedge clk);
    #1;
    restart = 1'b1;
    @(posedge clk);
    #1;
    restart = 1'b0;
    obs_q.delete();
  endtask

  // Model: a frame either is rejected on length, or writes every word in order and
  // finishes done only when the checksum byte equals the XOR of the data bytes.
  task automatic run_frame(input string name, input int n, input logic [7:0] mask,
                           input int max_stall);
    logic [7:0] x = 8'd0;
    bit bad;
    bit exp_done;
    logic [15:0] n16;
    n16 = 16'(n);
    bad = (n == 0) || (n > DEPTH);
    exp_q.delete();
    send_byte(n16[7:0], max_stall);
    send_byte(n16[15:8], max_stall);
    if (!bad) begin
      for (int w = 0; w < n; w++) begin
        for (int k = 0; k < 4; k++) begin
          logic [7:0] b;
          b = words[w][8*k +: 8];
          x ^= b;
          send_byte(b, max_stall);
        end
        exp_q.push_back({8'(w), words[w]});
      end
      send_byte(x ^ mask, max_stall);
    end
    exp_done = !bad && (mask == 8'd0);
    idle(3);
    check({name, "_nwrites"}, obs_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      check({name, "_addr"}, obs_q[i][39:32], exp_q[i][39:32]);
      check({name, "_wdata"}, obs_q[i][31:0], exp_q[i][31:0]);
    end
    check({name, "_done"}, done, exp_done);
    check({name, "_error"}, error, !exp_done);
    check({name, "_cpu_rst"}, cpu_rst, !exp_done);
    check({name, "_in_ready"}, in_ready, 0);
    $display("frame %s: N=%0d mask=%0h writes=%0d done=%0b error=%0b",
             name, n, mask, obs_q.size(), done, error);
  endtask

  initial begin
    idle(2);
    rst = 1'b0;
    check("rst_in_ready", in_ready, 1);
    check("rst_we", imem_we, 0);
    check("rst_addr", imem_addr, 0);
    check("rst_wdata", imem_wdata, 0);
    check("rst_cpu_rst", cpu_rst, 1);
    check("rst_done", done, 0);
    check("rst_error", error, 0);

    // Reference frame 01 00 78 56 34 12 08.
    words[0] = 32'h12345678;
    obs_q.delete();
    run_frame("t1", 1, 8'h00, 0);

    pulse_restart();
    check("restart_cpu_rst", cpu_rst, 1);
    check("restart_done", done, 0);
    for (int i = 0; i < 3; i++) words[i] = $urandom;
    run_frame("t2_stall", 3, 8'h00, 4);

    pulse_restart();
    run_frame("t3_len0", 0, 8'h00, 0);
    pulse_restart();
    run_frame("t3_lenbig", DEPTH + 1, 8'h00, 0);

    pulse_restart();
    for (int i = 0; i < 2; i++) words[i] = $urandom;
    run_frame("t4_badcsum", 2, 8'h01, 1);

    // Restart in the middle of word 1, the second attempt is a clean N=1 frame.
    pulse_restart();
    send_byte(8'h01, 0);
    send_byte(8'h00, 0);
    send_byte(8'hAA, 0);
    send_byte(8'hBB, 0);
    @(posedge clk);
    #1;
    restart  = 1'b1;
    in_valid = 1'b1;
    in_data  = 8'h05;
    @(negedge clk);
    check("t5_restart_ready", in_ready, 0);
    @(posedge clk);
    #1;
    restart  = 1'b0;
    in_valid = 1'b0;
    obs_q.delete();
    words[0] = $urandom;
    run_frame("t5_after_restart", 1, 8'h00, 1);

    for (int r = 0; r < 6; r++) begin
      int n;
      logic [7:0] m;
      n = $urandom_range(1, 8);
      m = ($urandom_range(0, 2) == 0) ? 8'($urandom_range(1, 255)) : 8'h00;
      for (int i = 0; i < n; i++) words[i] = $urandom;
      pulse_restart();
      run_frame($sformatf("rand%0d", r), n, m, 2);
    end

    pulse_restart();
    for (int i = 0; i < DEPTH; i++) words[i] = $urandom;
    run_frame("full_depth", DEPTH, 8'h00, 0);

    // rst in the middle of a data word with a byte on offer.
    pulse_restart();
    send_byte(8'h01, 0);
    send_byte(8'h00, 0);
    send_byte(8'h11, 0);
    in_valid = 1'b1;
    in_data  = 8'h22;
    rst      = 1'b1;
    @(posedge clk);
    #1;
    check("t6_we", imem_we, 0);
    check("t6_addr", imem_addr, 0);
    check("t6_wdata", imem_wdata, 0);
    check("t6_cpu_rst", cpu_rst, 1);
    check("t6_done", done, 0);
    check("t6_error", error, 0);
    check("t6_in_ready", in_ready, 1);
    in_valid = 1'b0;
    rst      = 1'b0;
    obs_q.delete();
    words[0] = $urandom;
    run_frame("t6_after_rst", 1, 8'h00, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
